// File: rtl/clkgen_multi_div.sv
// Multi-output divided clock generator with lock sequencing,
// runtime divisors and glitch-free per-channel enables.
//
// Ports:
//   inclk0     reference clock, all state updates on its rising edge
//   areset     synchronous active-high reset
//   div_cfg    new divisors, channel i in [i*DIV_W +: DIV_W]
//   cfg_load   strobe: capture div_cfg and restart the lock sequence
//   en         per-channel output enable, sampled at period boundaries
//   clk_out    registered divided clocks
//   locked     outputs valid and phase-aligned
//   lock_cnt_o lock counter, for debug
module clkgen_multi_div #(
  parameter int NUM_OUT = 3,
  parameter int DIV_W = 8,
  parameter logic [NUM_OUT*DIV_W-1:0] DIV_INIT = {8'd4, 8'd2, 8'd1},
  parameter int LOCK_CYCLES = 16,
  localparam int LCW = $clog2(LOCK_CYCLES + 1)
) (
  input  logic                     inclk0,
  input  logic                     areset,
  input  logic [NUM_OUT*DIV_W-1:0] div_cfg,
  input  logic                     cfg_load,
  input  logic [NUM_OUT-1:0]       en,
  output logic [NUM_OUT-1:0]       clk_out,
  output logic                     locked,
  output logic [LCW-1:0]           lock_cnt_o
);

  typedef enum logic {
    ST_LOCKING = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  state_t state, state_d;

  logic [LCW-1:0]     lock_cnt, lock_cnt_d;
  logic [DIV_W-1:0]   div [NUM_OUT];
  logic [DIV_W-1:0]   div_d [NUM_OUT];
  logic [DIV_W-1:0]   cnt [NUM_OUT];
  logic [DIV_W-1:0]   cnt_d [NUM_OUT];
  logic [DIV_W-1:0]   cnt_run [NUM_OUT];
  logic [NUM_OUT-1:0] en_eff, en_eff_d;
  logic [NUM_OUT-1:0] en_run, out_run;
  logic [NUM_OUT-1:0] clk_out_d;

  // Divisors of 0 or 1 cannot produce a clock; treat them as 2.
  function automatic logic [DIV_W-1:0] clamp(
    input logic [DIV_W-1:0] v
  );
    return (v[DIV_W-1:1] == '0) ? DIV_W'(2) : v;
  endfunction

  // Free-running per-channel step used once locked. The enable is
  // only resampled when the counter wraps, so a change never cuts
  // a high phase short.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      logic [DIV_W-1:0] half;
      half = div[i][DIV_W-1:1] + DIV_W'(div[i][0]);
      cnt_run[i] = (cnt[i] == div[i] - DIV_W'(1))
                 ? '0 : cnt[i] + DIV_W'(1);
      en_run[i] = (cnt_run[i] == '0) ? en[i] : en_eff[i];
      out_run[i] = en_run[i] & (cnt_run[i] < half);
    end
  end

  always_comb begin
    state_d = state;
    lock_cnt_d = lock_cnt;
    div_d = div;
    cnt_d = cnt;
    en_eff_d = en_eff;
    clk_out_d = clk_out;
    if (cfg_load) begin
      state_d = ST_LOCKING;
      lock_cnt_d = '0;
      en_eff_d = '0;
      clk_out_d = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        div_d[i] = clamp(div_cfg[i*DIV_W +: DIV_W]);
        cnt_d[i] = '0;
      end
    end else begin
      unique case (state)
        ST_LOCKING: begin
          lock_cnt_d = lock_cnt + LCW'(1);
          en_eff_d = '0;
          clk_out_d = '0;
          for (int i = 0; i < NUM_OUT; i++)
            cnt_d[i] = '0;
          // Lock edge: every channel starts its first period here,
          // so all outputs rise together.
          if (lock_cnt_d == LCW'(LOCK_CYCLES)) begin
            state_d = ST_RUN;
            en_eff_d = en;
            clk_out_d = en;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_run;
          en_eff_d = en_run;
          clk_out_d = out_run;
        end
        default: state_d = ST_LOCKING;
      endcase
    end
  end

  always_ff @(posedge inclk0) begin
    if (areset) begin
      state <= ST_LOCKING;
      lock_cnt <= '0;
      en_eff <= '0;
      clk_out <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        div[i] <= clamp(DIV_INIT[i*DIV_W +: DIV_W]);
        cnt[i] <= '0;
      end
    end else begin
      state <= state_d;
      lock_cnt <= lock_cnt_d;
      en_eff <= en_eff_d;
      clk_out <= clk_out_d;
      for (int i = 0; i < NUM_OUT; i++) begin
        div[i] <= div_d[i];
        cnt[i] <= cnt_d[i];
      end
    end
  end

  assign locked = (state == ST_RUN);
  assign lock_cnt_o = lock_cnt;

endmodule

// File: tb/tb_clkgen_multi_div.sv
// Directed bench for clkgen_multi_div: lock timing, divided
// waveforms, clamping, glitch-free enables, reset/reconfig corners.
module tb_clkgen_multi_div;

  logic        inclk0 = 1'b0;
  logic        areset;
  logic [23:0] div_cfg;
  logic        cfg_load;
  logic [2:0]  en;
  logic [2:0]  clk_out;
  logic        locked;
  logic [4:0]  lock_cnt_o;

  int checks = 0;
  int errors = 0;

  clkgen_multi_div dut (
    .inclk0     (inclk0),
    .areset     (areset),
    .div_cfg    (div_cfg),
    .cfg_load   (cfg_load),
    .en         (en),
    .clk_out    (clk_out),
    .locked     (locked),
    .lock_cnt_o (lock_cnt_o)
  );

  always #5 inclk0 = ~inclk0;

  task automatic step(input int n);
    repeat (n) @(posedge inclk0);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic lock_seq(input string tag);
    step(15);
    chk({tag, "_pre_locked"}, 32'(locked), 32'd0);
    chk({tag, "_pre_cnt"}, 32'(lock_cnt_o), 32'd15);
    step(1);
    chk({tag, "_locked"}, 32'(locked), 32'd1);
  endtask

  initial begin
    areset = 1'b1;
    cfg_load = 1'b0;
    div_cfg = '0;
    en = 3'b111;

    // Reset state
    step(1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_lcnt", 32'(lock_cnt_o), 32'd0);
    areset = 1'b0;

    // Defaults {4,2,2}
    lock_seq("def");
    chk("def_lock_clk", 32'(clk_out), 32'b111);
    chk("def_lcnt", 32'(lock_cnt_o), 32'd16);
    step(1); chk("def_e1", 32'(clk_out), 32'b100);
    step(1); chk("def_e2", 32'(clk_out), 32'b011);
    step(1); chk("def_e3", 32'(clk_out), 32'b000);
    step(1); chk("def_e4", 32'(clk_out), 32'b111);
    step(3); chk("def_sat", 32'(lock_cnt_o), 32'd16);

    // Odd divisors: ch2=5, ch1=3, ch0=7
    div_cfg = {8'd5, 8'd3, 8'd7};
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    chk("odd_unlock", 32'(locked), 32'd0);
    chk("odd_clk0", 32'(clk_out), 32'd0);
    chk("odd_lcnt0", 32'(lock_cnt_o), 32'd0);
    lock_seq("odd");
    chk("odd_lock_clk", 32'(clk_out), 32'b111);
    for (int k = 1; k <= 105; k++) begin
      logic [2:0] e;
      step(1);
      e = {((k % 5) < 3), ((k % 3) < 2), ((k % 7) < 4)};
      chk($sformatf("odd_k%0d", k), 32'(clk_out), 32'(e));
    end

    // Clamp: 0 and 1 behave as 2
    div_cfg = {8'd0, 8'd1, 8'd2};
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    lock_seq("clp");
    chk("clp_l", 32'(clk_out), 32'b111);
    step(1); chk("clp_e1", 32'(clk_out), 32'b000);
    step(1); chk("clp_e2", 32'(clk_out), 32'b111);
    step(1); chk("clp_e3", 32'(clk_out), 32'b000);

    // Glitch-free enable on ch2 with D=8
    div_cfg = {8'd8, 8'd2, 8'd2};
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    lock_seq("gf");
    chk("gf_c0", 32'(clk_out[2]), 32'd1);
    step(1); chk("gf_c1", 32'(clk_out[2]), 32'd1);
    en = 3'b011;
    step(1); chk("gf_c2", 32'(clk_out[2]), 32'd1);
    step(1); chk("gf_c3", 32'(clk_out[2]), 32'd1);
    step(1); chk("gf_c4", 32'(clk_out[2]), 32'd0);
    step(3); chk("gf_c7", 32'(clk_out[2]), 32'd0);
    step(1); chk("gf_off_c0", 32'(clk_out[2]), 32'd0);
    step(2); chk("gf_off_c2", 32'(clk_out[2]), 32'd0);
    step(3);
    en = 3'b111;
    step(1); chk("gf_re_c6", 32'(clk_out[2]), 32'd0);
    step(1); chk("gf_re_c7", 32'(clk_out[2]), 32'd0);
    step(1); chk("gf_re_c0", 32'(clk_out[2]), 32'd1);
    step(1); chk("gf_re_c1", 32'(clk_out[2]), 32'd1);

    // Reset while locked; cfg_load ignored during reset
    areset = 1'b1;
    cfg_load = 1'b1;
    div_cfg = {8'd3, 8'd3, 8'd3};
    step(1);
    areset = 1'b0;
    cfg_load = 1'b0;
    chk("mr_locked", 32'(locked), 32'd0);
    chk("mr_clk", 32'(clk_out), 32'd0);
    chk("mr_lcnt", 32'(lock_cnt_o), 32'd0);
    lock_seq("mr");
    chk("mr_l", 32'(clk_out), 32'b111);
    step(1); chk("mr_e1", 32'(clk_out), 32'b100);
    step(1); chk("mr_e2", 32'(clk_out), 32'b011);

    // Second cfg_load at lock_cnt=10
    div_cfg = {8'd4, 8'd2, 8'd2};
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    step(10);
    chk("re_l10", 32'(lock_cnt_o), 32'd10);
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    chk("re_l0", 32'(lock_cnt_o), 32'd0);
    lock_seq("re");

    // cfg_load held at the would-be lock edge
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    step(15);
    chk("hold_l15", 32'(lock_cnt_o), 32'd15);
    cfg_load = 1'b1;
    step(1);
    chk("hold_nolock", 32'(locked), 32'd0);
    chk("hold_lcnt", 32'(lock_cnt_o), 32'd0);
    step(2);
    chk("hold_still", 32'(locked), 32'd0);
    cfg_load = 1'b0;
    lock_seq("hold");
    chk("hold_clk", 32'(clk_out), 32'b111);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
